iir_p3_serializer: RTL



---
 rtl/iir_p3_pkg.sv | 28 ++
 rtl/iir_word_fifo.sv | 57 +++++
 rtl/iir_p3_serializer.sv | 72 +++++++
 3 files changed

// File: rtl/iir_p3_pkg.sv
// Shared constants and helpers for the 3-parallel IIR datapath.
// Lane 0 is the oldest sample and sits in the MSB field.
package iir_p3_pkg;

  localparam int IIR_DW    = 32;
  localparam int IIR_LANES = 3;
  localparam int IIR_WW    = IIR_DW * IIR_LANES;

  typedef logic [1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(IIR_LANES - 1);

  function automatic logic [IIR_DW-1:0] lane_slice(
    input logic [IIR_WW-1:0] w,
    input lane_t             l
  );
    logic [IIR_DW-1:0] s;
    s = '0;
    unique case (l)
      2'd0:    s = w[2*IIR_DW +: IIR_DW];
      2'd1:    s = w[1*IIR_DW +: IIR_DW];
      2'd2:    s = w[0*IIR_DW +: IIR_DW];
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/iir_word_fifo.sv
// Circular word buffer: storage, pointers and explicit level.
// Caller guarantees no write when full and no read when empty.
module iir_word_fifo
  import iir_p3_pkg::*;
#(
  parameter int W     = IIR_WW,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        (wr_en & ~rd_en): level <= level + 1'b1;
        (rd_en & ~wr_en): level <= level - 1'b1;
        default:          level <= level;
      endcase
    end
  end

endmodule

// File: rtl/iir_p3_serializer.sv
// Packed 3-lane word to 1-sample-per-beat stream converter.
// Lane 0 of the head word is emitted first.
module iir_p3_serializer
  import iir_p3_pkg::*;
#(
  parameter int DW    = IIR_DW,
  parameter int LANES = IIR_LANES,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW*LANES-1:0]    data_in,
  input  logic                   data_in_en,
  output logic                   in_ready,
  output logic [DW-1:0]          data_out,
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  logic [DW*LANES-1:0] head;
  logic                full;
  logic                empty;
  lane_t               lane;
  logic [DW-1:0]       hold_q;
  logic                push;
  logic                beat;
  logic                pop;

  assign in_ready       = ~full;
  assign data_out_valid = ~empty;
  assign push           = data_in_en & in_ready;
  assign beat           = data_out_valid & data_out_ready;
  assign pop            = beat & (lane == LAST_LANE);

  // Hold the last shown sample while the buffer is empty.
  assign data_out = data_out_valid ? lane_slice(head, lane)
                                   : hold_q;

  iir_word_fifo #(
    .W     (DW*LANES),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= '0;
      overflow <= 1'b0;
      hold_q   <= '0;
    end else begin
      hold_q <= data_out;
      if (beat) begin
        lane <= pop ? lane_t'(0) : lane + 1'b1;
      end
      if (data_in_en & ~in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
